lc3_mem_io: RTL and testbench
=============================

# lc3_mem_io

Unified memory and memory-mapped I/O block sitting directly downstream of the LC-3 `dut` core, driven by its `address`/`writeEnable`/`dataToMemory` outputs and supplying `dataFromMemory`. It holds a word-addressed RAM and implements the LC-3 keyboard (KBSR/KBDR) and display (DSR/DDR) device registers. The display path is buffered by a small output FIFO with a ready/valid drain interface.

## Interface
- `ADDR_BITS`, 10: RAM holds 2^ADDR_BITS 16-bit words at 0x0000..2^ADDR_BITS-1.
- `FIFO_DEPTH`, 4: display FIFO entries; power of two, 2..16.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted at 0.
- `address`  in  16  word address from core.
- `writeEnable`  in  1  write strobe; each high cycle is one write.
- `dataToMemory`  in  16  write data.
- `dataFromMemory`  out  16  read data, combinational from `address`.
- `kbd_valid`  in  1  keyboard offers a byte.
- `kbd_data`  in  8  keyboard byte.
- `kbd_ready`  out  1  block can accept a keyboard byte.
- `disp_valid`  out  1  FIFO head valid.
- `disp_data`  out  8  FIFO head byte.
- `disp_ready`  in  1  display consumes head.

## Operation
- Address map: RAM region; 0xFE00 KBSR; 0xFE02 KBDR; 0xFE04 DSR; 0xFE06 DDR; all else unmapped (read 0, write ignored).
- RAM: asynchronous read, synchronous write when `writeEnable`=1 and address in RAM region. Not cleared by reset; simulation initial contents 0.
- KBSR: bit15 = key-full flag (read-only), bit14 = interrupt-enable (R/W, reset 0), other bits read 0.
- Keyboard capture: `kbd_ready` = ~KBSR[15]. On edge with `kbd_valid` & `kbd_ready`, KBDR <= {8'h00, `kbd_data`}, KBSR[15] <= 1.
- KBDR read-clear: a registered flag `prev_kbdr` records that `address` was 0xFE02 last cycle. KBSR[15] clears on the first edge where `address`=0xFE02, `writeEnable`=0 and `prev_kbdr`=0. Holding the address for multiple cycles clears once. Writes to KBDR ignored.
- Capture and clear never coincide (capture requires flag clear); a byte offered on the clear edge is captured on the following edge.
- DSR read: bit15 = FIFO not full; bits 4:0 = FIFO occupancy; rest 0. Writes ignored.
- DDR write: push `dataToMemory[7:0]` if FIFO not full. If full, the write is dropped. DDR reads return 0.
- FIFO: `disp_valid` = occupancy>0; `disp_data` = head byte. Pop on edge with `disp_valid` & `disp_ready`.
- Simultaneous push and pop: both take effect and occupancy is unchanged. This includes the full case; the pop is evaluated first, so the push is accepted. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Read latency 0 cycles: `dataFromMemory` is valid in the same cycle as `address`. The core samples it on the next edge.
- Write latency 1 edge: a RAM/register write is visible to combinational reads immediately after the edge.
- DDR write to `disp_valid`: 1 edge when the FIFO is empty.
- Reset values: KBSR=0x0000, KBDR=0x0000, `prev_kbdr`=0, FIFO empty.
- Outputs during reset: `kbd_ready`=1, `disp_valid`=0, `disp_data`=0x00 (the head reads 0 when empty).
- Reset mid-operation: FIFO contents and pending key discarded immediately (asynchronous); RAM retained.

## Configuration
- `LC3_DISP_OVF_EN` defined: a 16-bit saturating overflow counter increments on each dropped DDR write.
  - Counter readable at 0xFE08; any write to 0xFE08 clears it to 0.
  - Reset value 0.
  - A clear and an increment on the same edge: the clear wins.
- Undefined: no counter; 0xFE08 is unmapped; dropped writes are silent.

## Test plan
- Write 0x1234 to 0x0005, then read 0x0005 -> `dataFromMemory`=0x1234 the cycle after the write edge. Read 0x3000 -> 0x0000.
- `kbd_valid`=1, `kbd_data`=0x41 -> KBSR reads 0x8000, KBDR reads 0x0041, `kbd_ready`=0.
  - Hold `address`=0xFE02 for 3 cycles -> KBSR cleared once.
  - Next key 0x42 captured one edge later.
- Write DDR 0x0061, 0x0062 with `disp_ready`=0 -> DSR=0x8002, `disp_data`=0x61. Raise `disp_ready` for 2 cycles -> 0x62 then `disp_valid`=0.
- Fill FIFO (4 writes), write 0x0078 -> dropped, DSR=0x0004. With `LC3_DISP_OVF_EN`: 0xFE08 reads 0x0001; write 0xFE08 -> reads 0x0000.
- Full FIFO, DDR write with `disp_ready`=1 on the same edge -> occupancy stays 4, new byte is last out.
- Assert `reset` low mid-drain with 3 entries and KBSR[15]=1 -> `disp_valid`=0, `kbd_ready`=1 immediately; RAM word 0x0005 still 0x1234.

Source files
------------

// File: rtl/lc3_mem_io.sv
// lc3_mem_io: LC-3 word RAM plus keyboard (KBSR/KBDR) and FIFO-buffered display (DSR/DDR).
// Define LC3_DISP_OVF_EN to add a saturating dropped-DDR-write counter at 0xFE08.
module lc3_mem_io #(
    parameter int ADDR_BITS  = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        writeEnable,
    input  logic [15:0] dataToMemory,
    output logic [15:0] dataFromMemory,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);
    localparam logic [15:0] A_KBSR = 16'hFE00;
    localparam logic [15:0] A_KBDR = 16'hFE02;
    localparam logic [15:0] A_DSR  = 16'hFE04;
    localparam logic [15:0] A_DDR  = 16'hFE06;
`ifdef LC3_DISP_OVF_EN
    localparam logic [15:0] A_OVF  = 16'hFE08;
`endif

    logic [15:0]   r_mem [2**ADDR_BITS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          r_kbd_full;
    logic          r_kbd_ie;
    logic          r_prev_kbdr;
    logic [7:0]    r_kbdr;

    logic          w_ram_sel;
    logic          w_full;
    logic          w_pop;
    logic          w_ddr_wr;
    logic          w_push;
    logic          w_kbd_clr;
    logic          w_capture;
    logic [4:0]    w_occ;

    assign w_ram_sel  = (address[15:ADDR_BITS] == '0);
    assign w_full     = (r_count == FULL_C);
    assign w_occ      = 5'(r_count);
    assign disp_valid = (r_count != '0);
    assign disp_data  = disp_valid ? r_fifo[r_rd] : 8'h00;
    assign kbd_ready  = ~r_kbd_full;
    assign w_pop      = disp_valid & disp_ready;
    assign w_ddr_wr   = writeEnable & (address == A_DDR);
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign w_push     = w_ddr_wr & (~w_full | w_pop);
    assign w_kbd_clr  = (address == A_KBDR) & ~writeEnable & ~r_prev_kbdr;
    assign w_capture  = kbd_valid & ~r_kbd_full;

`ifdef LC3_DISP_OVF_EN
    logic [15:0] r_ovf;
    logic        w_drop;
    assign w_drop = w_ddr_wr & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= '0;
        end else if (writeEnable && address == A_OVF) begin
            r_ovf <= '0;
        end else if (w_drop && r_ovf != 16'hFFFF) begin
            r_ovf <= r_ovf + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (writeEnable && w_ram_sel) begin
            r_mem[address[ADDR_BITS-1:0]] <= dataToMemory;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr] <= dataToMemory[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd        <= '0;
            r_wr        <= '0;
            r_count     <= '0;
            r_kbd_full  <= 1'b0;
            r_kbd_ie    <= 1'b0;
            r_prev_kbdr <= 1'b0;
            r_kbdr      <= '0;
        end else begin
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (writeEnable && address == A_KBSR) begin
                r_kbd_ie <= dataToMemory[14];
            end
            if (w_capture) begin
                r_kbd_full <= 1'b1;
                r_kbdr     <= kbd_data;
            end else if (w_kbd_clr) begin
                r_kbd_full <= 1'b0;
            end
            r_prev_kbdr <= (address == A_KBDR);
        end
    end

    always_comb begin
        dataFromMemory = '0;
        if (w_ram_sel) begin
            dataFromMemory = r_mem[address[ADDR_BITS-1:0]];
        end else begin
            case (address)
                A_KBSR:  dataFromMemory = {r_kbd_full, r_kbd_ie, 14'b0};
                A_KBDR:  dataFromMemory = {8'h00, r_kbdr};
                A_DSR:   dataFromMemory = {~w_full, 10'b0, w_occ};
`ifdef LC3_DISP_OVF_EN
                A_OVF:   dataFromMemory = r_ovf;
`endif
                default: dataFromMemory = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_mem_io.sv
// tb_lc3_mem_io: directed stimulus, queue-based reference model checked every
// cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_lc3_mem_io;
    localparam int D = 4;
    localparam int RAM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address = 16'h3000;
    logic        writeEnable = 1'b0;
    logic [15:0] dataToMemory = 16'h0000;
    logic [15:0] dataFromMemory;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        kbd_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    lc3_mem_io #(.ADDR_BITS(10), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .address(address),
        .writeEnable(writeEnable), .dataToMemory(dataToMemory),
        .dataFromMemory(dataFromMemory), .kbd_valid(kbd_valid),
        .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .disp_ready(disp_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_mem [int];
    bit          m_full = 0;
    bit          m_ie = 0;
    bit          m_prev = 0;
    logic [7:0]  m_kbdr = 8'h00;
    logic [7:0]  m_q [$];
    logic [15:0] m_ovf = 16'h0000;

    function automatic logic [15:0] m_read(input logic [15:0] a);
        int n;
        n = m_q.size();
        if (int'(a) < RAM_WORDS)
            return m_mem.exists(int'(a)) ? m_mem[int'(a)] : 16'h0000;
        if (a == 16'hFE00) return {m_full, m_ie, 14'b0};
        if (a == 16'hFE02) return {8'h00, m_kbdr};
        if (a == 16'hFE04) return {(n < D), 10'b0, 5'(n)};
`ifdef LC3_DISP_OVF_EN
        if (a == 16'hFE08) return m_ovf;
`endif
        return 16'h0000;
    endfunction

    always @(posedge clk or negedge reset) begin
        bit pop, push, drop, clr, cap;
        if (!reset) begin
            m_full = 0; m_ie = 0; m_prev = 0; m_kbdr = 8'h00;
            m_q.delete(); m_ovf = 16'h0000;
        end else begin
            pop  = (m_q.size() > 0) && disp_ready;
            push = 0;
            drop = 0;
            clr  = (address == 16'hFE02) && !writeEnable && !m_prev;
            cap  = kbd_valid && !m_full;
            if (writeEnable) begin
                if (int'(address) < RAM_WORDS) m_mem[int'(address)] = dataToMemory;
                else if (address == 16'hFE00) m_ie = dataToMemory[14];
                else if (address == 16'hFE06) begin
                    if (m_q.size() < D || pop) push = 1;
                    else drop = 1;
                end
`ifdef LC3_DISP_OVF_EN
                else if (address == 16'hFE08) m_ovf = 16'h0000;
`endif
            end
`ifdef LC3_DISP_OVF_EN
            if (drop && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'h1;
`endif
            if (pop) void'(m_q.pop_front());
            if (push) m_q.push_back(dataToMemory[7:0]);
            if (cap) begin
                m_full = 1;
                m_kbdr = kbd_data;
            end else if (clr) begin
                m_full = 0;
            end
            m_prev = (address == 16'hFE02);
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_rdata", dataFromMemory, m_read(address));
        chk("model_kbd_ready", 16'(kbd_ready), 16'(!m_full));
        chk("model_disp_valid", 16'(disp_valid), 16'(m_q.size() > 0));
        chk("model_disp_data", 16'(disp_data),
            16'((m_q.size() > 0) ? m_q[0] : 8'h00));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a;
        writeEnable = 1'b1;
        dataToMemory = d;
        tick();
        writeEnable = 1'b0;
        address = 16'h3000;
    endtask

    task automatic peek(input string nm, input logic [15:0] a, input logic [15:0] exp);
        address = a;
        #1;
        chk(nm, dataFromMemory, exp);
    endtask

    initial begin
        #2;
        chk("rst_kbd_ready", 16'(kbd_ready), 16'h1);
        chk("rst_disp_valid", 16'(disp_valid), 16'h0);
        chk("rst_disp_data", 16'(disp_data), 16'h00);
        peek("rst_dsr", 16'hFE04, 16'h8000);
        address = 16'h3000;
        tick(); tick();
        reset = 1'b1;
        tick();

        wr(16'h0005, 16'h1234);
        peek("ram_0005", 16'h0005, 16'h1234);
        peek("unmapped_3000", 16'h3000, 16'h0000);
        tick();
        wr(16'h03FF, 16'hBEEF);
        wr(16'h0400, 16'h5555);
        peek("ram_top", 16'h03FF, 16'hBEEF);
        peek("past_ram", 16'h0400, 16'h0000);
        address = 16'h3000;
        tick();

        kbd_valid = 1'b1; kbd_data = 8'h41;
        tick();
        kbd_valid = 1'b0;
        peek("kbsr_full", 16'hFE00, 16'h8000);
        chk("kbd_ready_full", 16'(kbd_ready), 16'h0);
        peek("kbdr_41", 16'hFE02, 16'h0041);
        kbd_valid = 1'b1; kbd_data = 8'h42;
        tick();
        #1;
        chk("kbd_clear_edge1", 16'(kbd_ready), 16'h1);
        chk("kbdr_after_clr", dataFromMemory, 16'h0041);
        tick();
        #1;
        chk("kbd_cap_42", dataFromMemory, 16'h0042);
        chk("kbd_ready_42", 16'(kbd_ready), 16'h0);
        tick();
        #1;
        chk("kbd_clear_once", 16'(kbd_ready), 16'h0);
        kbd_valid = 1'b0;
        peek("kbsr_still_full", 16'hFE00, 16'h8000);
        tick();
        wr(16'hFE00, 16'h4000);
        peek("kbsr_ie", 16'hFE00, 16'hC000);
        address = 16'hFE02;
        tick();
        peek("kbsr_cleared", 16'hFE00, 16'h4000);
        wr(16'hFE02, 16'hFFFF);
        peek("kbdr_wr_ignored", 16'hFE02, 16'h0042);
        wr(16'hFE00, 16'h0000);
        tick();

        wr(16'hFE06, 16'h0061);
        #1;
        chk("ddr_valid_1edge", 16'(disp_valid), 16'h1);
        chk("ddr_head_61", 16'(disp_data), 16'h61);
        wr(16'hFE06, 16'h0062);
        peek("dsr_two", 16'hFE04, 16'h8002);
        chk("head_still_61", 16'(disp_data), 16'h61);
        address = 16'h3000;
        disp_ready = 1'b1;
        tick();
        #1;
        chk("head_62", 16'(disp_data), 16'h62);
        tick();
        #1;
        chk("drained", 16'(disp_valid), 16'h0);
        disp_ready = 1'b0;

        for (int i = 0; i < D; i++) wr(16'hFE06, 16'h0070 + 16'(i));
        wr(16'hFE06, 16'h0078);
        peek("dsr_full", 16'hFE04, 16'h0004);
        chk("full_head_70", 16'(disp_data), 16'h70);
`ifdef LC3_DISP_OVF_EN
        peek("ovf_one", 16'hFE08, 16'h0001);
        tick();
        wr(16'hFE08, 16'h1234);
        peek("ovf_cleared", 16'hFE08, 16'h0000);
`else
        peek("fe08_unmapped", 16'hFE08, 16'h0000);
`endif
        address = 16'hFE06; writeEnable = 1'b1; dataToMemory = 16'h0079;
        disp_ready = 1'b1;
        tick();
        writeEnable = 1'b0; disp_ready = 1'b0;
        peek("dsr_pushpop_full", 16'hFE04, 16'h0004);
        chk("head_71", 16'(disp_data), 16'h71);
        address = 16'h3000;
        disp_ready = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("last_out_79", 16'(disp_data), 16'h79);
        tick();
        #1;
        chk("empty_after_79", 16'(disp_valid), 16'h0);
        disp_ready = 1'b0;

        kbd_valid = 1'b1; kbd_data = 8'h55;
        tick();
        kbd_valid = 1'b0;
        wr(16'hFE06, 16'h0081);
        wr(16'hFE06, 16'h0082);
        wr(16'hFE06, 16'h0083);
        wr(16'hFE06, 16'h0084);
        disp_ready = 1'b1;
        tick();
        chk("pre_rst_kbd_ready", 16'(kbd_ready), 16'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", 16'(disp_valid), 16'h0);
        chk("rst_mid_kbd_ready", 16'(kbd_ready), 16'h1);
        chk("rst_mid_data", 16'(disp_data), 16'h00);
        peek("ram_retained", 16'h0005, 16'h1234);
        #1;
        peek("rst_kbsr", 16'hFE00, 16'h0000);
        disp_ready = 1'b0;
        address = 16'h3000;
        tick(); tick();
        reset = 1'b1;
        tick();
        peek("post_rst_ram", 16'h03FF, 16'hBEEF);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
